// File: rtl/scan_priority_encoder.sv
// Registered N-to-log2(N) index encoder: one-hot, priority and scan modes,
// with valid/ready handshakes on both the capture and the beat side.
module scan_priority_encoder #(
  parameter  int N = 16,
  localparam int W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [1:0]   mode,
  input  logic [N-1:0] d,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] o,
  output logic         err,
  output logic         last,
  output logic         out_valid,
  input  logic         out_ready
);

  // state | meaning
  // IDLE  | no operation in progress, waiting for a capture
  // EMIT  | presenting beats derived from the captured mask and mode
  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [N-1:0] mask_q, mask_d;
  logic [1:0]   mode_q, mode_d;

  logic [W-1:0] lo_idx;
  logic [W-1:0] hi_idx;
  logic         mask_zero;
  logic         mask_single;
  logic [W-1:0] beat_o;
  logic         beat_err;
  logic         beat_last;
  logic         accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      mode_q  <= mode_d;
    end
  end

  always_comb begin
    lo_idx = '0;
    hi_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (mask_q[i]) lo_idx = W'(i);
    end
    for (int j = 0; j < N; j++) begin
      if (mask_q[j]) hi_idx = W'(j);
    end
  end

  // Clearing the lowest set bit both advances the scan and tests for a single bit.
  assign mask_zero   = (mask_q == '0);
  assign mask_single = ~mask_zero & ((mask_q & (mask_q - N'(1))) == '0);

  always_comb begin
    beat_o    = '0;
    beat_err  = 1'b0;
    beat_last = 1'b1;
    case (mode_q)
      2'd0: begin
        if (mask_single) beat_o = lo_idx;
        else             beat_err = 1'b1;
      end
      2'd2: begin
        if (mask_zero) begin
          beat_err = 1'b1;
        end else begin
          beat_o    = lo_idx;
          beat_last = mask_single;
        end
      end
      default: begin
        if (mask_zero) beat_err = 1'b1;
        else           beat_o = hi_idx;
      end
    endcase
  end

  assign out_valid = (state_q == EMIT);
  assign o         = out_valid ? beat_o : '0;
  assign err       = out_valid & beat_err;
  assign last      = out_valid & beat_last;
  assign in_ready  = (state_q == IDLE) & en & ~rst;
  assign accept    = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    mode_d  = mode_q;
    case (state_q)
      IDLE: begin
        if (in_valid & in_ready) begin
          state_d = EMIT;
          mask_d  = d;
          mode_d  = mode;
        end
      end
      EMIT: begin
        if (~en | (accept & beat_last)) begin
          state_d = IDLE;
          mask_d  = '0;
        end else if (accept) begin
          mask_d = mask_q & (mask_q - N'(1));
        end
      end
      default: begin
        state_d = IDLE;
        mask_d  = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_scan_priority_encoder.sv
// Randomised self-checking bench for scan_priority_encoder (N=16, plus N=4 and
// N=64 instances for the width extremes), checked against a set-index-list model.
module tb_scan_priority_encoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, en;

  logic [15:0] d16;  logic [1:0] m16;  logic iv16, ir16, r16, ov16, err16, last16;  logic [3:0] o16;
  logic [3:0]  d4;   logic [1:0] m4;   logic iv4, ir4, r4, ov4, err4, last4;        logic [1:0] o4;
  logic [63:0] d64;  logic [1:0] m64;  logic iv64, ir64, r64, ov64, err64, last64;  logic [5:0] o64;

  int tests = 0;
  int fails = 0;

  int exp_o[$];
  bit exp_err[$];
  bit exp_last[$];

  scan_priority_encoder #(.N(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .mode(m16), .d(d16), .in_valid(iv16), .in_ready(ir16),
    .o(o16), .err(err16), .last(last16), .out_valid(ov16), .out_ready(r16));

  scan_priority_encoder #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(m4), .d(d4), .in_valid(iv4), .in_ready(ir4),
    .o(o4), .err(err4), .last(last4), .out_valid(ov4), .out_ready(r4));

  scan_priority_encoder #(.N(64)) u_dut64 (
    .clk(clk), .rst(rst), .en(en), .mode(m64), .d(d64), .in_valid(iv64), .in_ready(ir64),
    .o(o64), .err(err64), .last(last64), .out_valid(ov64), .out_ready(r64));

  // Expected beat list: the ascending list of set indices, interpreted per mode.
  function automatic void model(input logic [63:0] dv, input int n, input logic [1:0] m);
    int idx[$];
    exp_o.delete(); exp_err.delete(); exp_last.delete();
    for (int i = 0; i < n; i++) if (dv[i]) idx.push_back(i);
    if (idx.size() == 0 || (m == 2'd0 && idx.size() != 1)) begin
      exp_o.push_back(0); exp_err.push_back(1'b1); exp_last.push_back(1'b1);
    end else if (m == 2'd2) begin
      foreach (idx[k]) begin
        exp_o.push_back(idx[k]); exp_err.push_back(1'b0); exp_last.push_back(k == idx.size() - 1);
      end
    end else if (m == 2'd0) begin
      exp_o.push_back(idx[0]); exp_err.push_back(1'b0); exp_last.push_back(1'b1);
    end else begin
      exp_o.push_back(idx[idx.size() - 1]); exp_err.push_back(1'b0); exp_last.push_back(1'b1);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic run16(input logic [15:0] dv, input logic [1:0] m, input int pct,
                       input int sbeat, input int sn, input bit noise);
    int beat = 0;
    int stalled = 0;
    int cyc = 0;
    logic [3:0] eo;
    bit rdy;
    model({48'b0, dv}, 16, m);
    d16 = dv; m16 = m; iv16 = 1'b1;
    tests++;
    if (ir16 !== 1'b1) begin fails++; $display("FAIL cap_ready: in_ready=%b want 1", ir16); end
    step();
    iv16 = noise; d16 = 16'($urandom); m16 = 2'($urandom);
    tests++;
    if (ov16 !== 1'b1) begin fails++; $display("FAIL latency: out_valid=%b want 1 (d=%h mode=%0d)", ov16, dv, m); end
    while (exp_o.size() > 0 && cyc < 300) begin
      if (ov16 !== 1'b1) begin
        tests++; fails++;
        $display("FAIL beat_valid: out_valid=%b want 1 at beat %0d (d=%h mode=%0d)", ov16, beat, dv, m);
        break;
      end
      eo = 4'(exp_o[0]);
      tests++;
      if (o16 !== eo || err16 !== exp_err[0] || last16 !== exp_last[0]) begin
        fails++;
        $display("FAIL beat: d=%h mode=%0d beat=%0d got o=%0d err=%b last=%b want o=%0d err=%b last=%b",
                 dv, m, beat, o16, err16, last16, eo, exp_err[0], exp_last[0]);
      end
      if (beat == sbeat && stalled < sn) begin
        rdy = 1'b0; stalled++;
      end else begin
        rdy = ($urandom_range(99) >= pct);
      end
      r16 = rdy;
      step();
      cyc++;
      if (rdy) begin
        void'(exp_o.pop_front()); void'(exp_err.pop_front()); void'(exp_last.pop_front());
        beat++;
      end
    end
    iv16 = 1'b0;
    tests++;
    if (exp_o.size() != 0) begin fails++; $display("FAIL beat_timeout: %0d beats left want 0", exp_o.size()); end
    tests++;
    if (ov16 !== 1'b0 || ir16 !== 1'b1) begin
      fails++; $display("FAIL end_state: out_valid=%b in_ready=%b want 0 1", ov16, ir16);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b1; iv16 = 1'b1; d16 = 16'h0400; m16 = 2'd0; r16 = 1'b1;
    step();
    tests++;
    if (ir16 !== 1'b0 || ov16 !== 1'b0 || o16 !== 4'd0) begin
      fails++; $display("FAIL reset1: in_ready=%b out_valid=%b o=%0d want 0 0 0", ir16, ov16, o16);
    end
    step();
    tests++;
    if (ir16 !== 1'b0 || ov16 !== 1'b0 || err16 !== 1'b0 || last16 !== 1'b0) begin
      fails++; $display("FAIL reset2: in_ready=%b out_valid=%b err=%b last=%b want 0 0 0 0", ir16, ov16, err16, last16);
    end
    rst = 1'b0; iv16 = 1'b0;
    #1;
    tests++;
    if (ir16 !== 1'b1) begin fails++; $display("FAIL reset_ready: in_ready=%b want 1", ir16); end
    step();
    tests++;
    if (ov16 !== 1'b0) begin fails++; $display("FAIL reset_nocap: out_valid=%b want 0", ov16); end
  endtask

  task automatic test_onehot();
    run16(16'h0400, 2'd0, 0, -1, 0, 1'b0);
    run16(16'h0000, 2'd0, 0, -1, 0, 1'b0);
    run16(16'h8001, 2'd0, 0, -1, 0, 1'b0);
    run16(16'h0001, 2'd0, 0, -1, 0, 1'b0);
  endtask

  task automatic test_priority();
    run16(16'h8001, 2'd1, 0, -1, 0, 1'b0);
    run16(16'h8001, 2'd3, 0, -1, 0, 1'b0);
    run16(16'h0000, 2'd1, 0, -1, 0, 1'b0);
    run16(16'h0000, 2'd3, 0, -1, 0, 1'b0);
  endtask

  task automatic test_scan_stall();
    run16(16'h8421, 2'd2, 0, 1, 3, 1'b0);
    run16(16'h0000, 2'd2, 0, -1, 0, 1'b0);
    run16(16'h0011, 2'd2, 0, 0, 2, 1'b1);
  endtask

  task automatic test_abort(input bit use_rst);
    en = 1'b1; d16 = 16'hFFFF; m16 = 2'd2; iv16 = 1'b1; r16 = 1'b1;
    step();
    iv16 = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tests++;
      if (ov16 !== 1'b1 || o16 !== 4'(k)) begin
        fails++; $display("FAIL abort_beat: out_valid=%b o=%0d want 1 %0d", ov16, o16, k);
      end
      step();
    end
    r16 = 1'b0;
    if (use_rst) rst = 1'b1;
    else         en = 1'b0;
    step();
    tests++;
    if (ov16 !== 1'b0 || o16 !== 4'd0 || last16 !== 1'b0) begin
      fails++; $display("FAIL abort_idle: out_valid=%b o=%0d last=%b want 0 0 0 (rst=%b)", ov16, o16, last16, use_rst);
    end
    rst = 1'b0; en = 1'b1;
    #1;
    tests++;
    if (ir16 !== 1'b1) begin fails++; $display("FAIL abort_ready: in_ready=%b want 1", ir16); end
    run16(16'h0002, 2'd2, 0, -1, 0, 1'b0);
  endtask

  task automatic test_random();
    logic [15:0] dv;
    for (int t = 0; t < 40; t++) begin
      case ($urandom_range(3))
        0:       dv = 16'($urandom);
        1:       dv = 16'(1) << $urandom_range(15);
        2:       dv = 16'h0000;
        default: dv = 16'($urandom) & 16'($urandom) & 16'($urandom);
      endcase
      run16(dv, 2'($urandom), 30, -1, 0, 1'b1);
    end
  endtask

  task automatic drv(input int n, input logic v, input logic [63:0] dv, input logic [1:0] m);
    if (n == 4) begin iv4 = v; d4 = dv[3:0]; m4 = m; end
    else        begin iv64 = v; d64 = dv; m64 = m; end
  endtask

  task automatic smp(input int n, output logic v, output logic [5:0] ov, output logic e,
                     output logic l, output logic ir);
    if (n == 4) begin v = ov4; ov = {4'b0, o4}; e = err4; l = last4; ir = ir4; end
    else        begin v = ov64; ov = o64; e = err64; l = last64; ir = ir64; end
  endtask

  task automatic sweep_op(input int n, input logic [63:0] dv, input logic [1:0] m);
    logic v, e, l, ir;
    logic [5:0] ov;
    int beat = 0;
    model(dv, n, m);
    smp(n, v, ov, e, l, ir);
    tests++;
    if (ir !== 1'b1) begin fails++; $display("FAIL sweep_ready N=%0d: in_ready=%b want 1", n, ir); end
    drv(n, 1'b1, dv, m);
    step();
    drv(n, 1'b0, 64'b0, 2'd0);
    while (exp_o.size() > 0) begin
      smp(n, v, ov, e, l, ir);
      tests++;
      if (v !== 1'b1 || ov !== 6'(exp_o[0]) || e !== exp_err[0] || l !== exp_last[0]) begin
        fails++;
        $display("FAIL sweep_beat N=%0d mode=%0d beat=%0d: valid=%b o=%0d err=%b last=%b want 1 %0d %b %b",
                 n, m, beat, v, ov, e, l, exp_o[0], exp_err[0], exp_last[0]);
      end
      step();
      void'(exp_o.pop_front()); void'(exp_err.pop_front()); void'(exp_last.pop_front());
      beat++;
    end
    smp(n, v, ov, e, l, ir);
    tests++;
    if (v !== 1'b0) begin fails++; $display("FAIL sweep_end N=%0d: out_valid=%b want 0", n, v); end
  endtask

  task automatic test_sweep(input int n);
    logic [63:0] all;
    all = (n == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << n) - 64'd1);
    sweep_op(n, 64'd1 << (n - 1), 2'd1);
    sweep_op(n, all, 2'd2);
    sweep_op(n, 64'd1, 2'd0);
  endtask

  initial begin
    rst = 1'b1; en = 1'b1;
    d16 = '0; m16 = '0; iv16 = 1'b0; r16 = 1'b1;
    d4 = '0;  m4 = '0;  iv4 = 1'b0;  r4 = 1'b1;
    d64 = '0; m64 = '0; iv64 = 1'b0; r64 = 1'b1;
    test_reset();
    test_onehot();
    test_priority();
    test_scan_stall();
    test_abort(1'b0);
    test_abort(1'b1);
    test_random();
    test_sweep(4);
    test_sweep(64);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
